// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//   Coin-return stage. Takes a change amount (in nickel units) and pays it out
//   one coin per en_1hz tick: quarter first, then dime, then nickel. It keeps a
//   count for each coin tube. Inserted coins add to a tube, and restock refills
//   every tube. If greedy payout cannot finish, short is raised.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   en_1hz              payout pacing tick (one cycle wide)
//   req_valid/ready     change request handshake, req_amount in nickel units
//   coin_quarter/dime/nickel
//                       insert pulses, one coin added to the matching tube
//   restock             level; refills all tubes to COIN_CAP while idle
//   out_quarter/dime/nickel
//                       registered one-cycle eject pulses (at most one high)
//   busy                high while dispensing
//   done                one-cycle pulse when a request finishes
//   short               sticky: last request was not paid in full
//   remaining           units still owed
//   cnt_q/cnt_d/cnt_n   tube counts
// -----------------------------------------------------------------------------
module change_dispenser #(
   parameter int AMT_W    = 8,
   parameter int COIN_CAP = 15,
   parameter int INIT_Q   = 8,
   parameter int INIT_D   = 8,
   parameter int INIT_N   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_1hz,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [AMT_W-1:0] req_amount,
   input  logic             coin_quarter,
   input  logic             coin_dime,
   input  logic             coin_nickel,
   input  logic             restock,
   output logic             out_quarter,
   output logic             out_dime,
   output logic             out_nickel,
   output logic             busy,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] remaining,
   output logic [3:0]       cnt_q,
   output logic [3:0]       cnt_d,
   output logic [3:0]       cnt_n
);

   typedef enum logic [0:0] {
      S_IDLE     = 1'b0,
      S_DISPENSE = 1'b1
   } state_t;

   localparam logic [3:0]       CAP      = 4'(COIN_CAP);
   localparam logic [AMT_W-1:0] Q_UNITS  = AMT_W'(5);
   localparam logic [AMT_W-1:0] D_UNITS  = AMT_W'(2);
   localparam logic [AMT_W-1:0] N_UNITS  = AMT_W'(1);
   // Tube index: 0 = quarter, 1 = dime, 2 = nickel
   localparam logic [2:0][3:0]  INIT_CNT = {4'(INIT_N), 4'(INIT_D), 4'(INIT_Q)};

   state_t           state_q, state_d;
   logic [AMT_W-1:0] remaining_q, remaining_d;
   logic             short_q, short_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             out_quarter_q, out_quarter_d;
   logic             out_dime_q, out_dime_d;
   logic             out_nickel_q, out_nickel_d;
   logic [2:0][3:0]  tube_cnt_q, tube_cnt_d;

   logic             elig_q, elig_d, elig_n;
   logic [2:0]       coin_in;
   logic [2:0]       eject;
   logic             refill;

   // Greedy eligibility. Each coin is considered only if every larger coin
   // is ineligible, so at most one of these is high at a time.
   assign elig_q = (remaining_q >= Q_UNITS) && (tube_cnt_q[0] != 4'd0);
   assign elig_d = !elig_q && (remaining_q >= D_UNITS) && (tube_cnt_q[1] != 4'd0);
   assign elig_n = !elig_q && !elig_d && (remaining_q >= N_UNITS) && (tube_cnt_q[2] != 4'd0);

   assign req_ready = (state_q == S_IDLE) && !restock;
   assign refill    = (state_q == S_IDLE) && restock;
   assign coin_in   = {coin_nickel, coin_dime, coin_quarter};
   assign eject     = {out_nickel_d, out_dime_d, out_quarter_d};

   // Next tube count. Refill wins over an insert in the same cycle. An insert
   // and an eject together cancel out. Both saturate, so counts never wrap.
   function automatic logic [3:0] tube_next(input logic [3:0] cnt,
                                            input logic       ins,
                                            input logic       ej,
                                            input logic       fill);
      logic [3:0] nxt;
      nxt = cnt;
      if (fill) begin
         nxt = CAP;
      end else if (ins && !ej) begin
         nxt = (cnt >= CAP) ? CAP : cnt + 4'd1;
      end else if (ej && !ins) begin
         nxt = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
      end
      return nxt;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_tube
         assign tube_cnt_d[gi] = tube_next(tube_cnt_q[gi], coin_in[gi], eject[gi], refill);
      end
   endgenerate

   always_comb begin
      state_d       = state_q;
      remaining_d   = remaining_q;
      short_d       = short_q;
      done_d        = 1'b0;
      out_quarter_d = 1'b0;
      out_dime_d    = 1'b0;
      out_nickel_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               state_d     = S_DISPENSE;
               remaining_d = req_amount;
               short_d     = 1'b0;
            end
         end
         S_DISPENSE: begin
            if (remaining_q == '0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (!(elig_q || elig_d || elig_n)) begin
               // Greedy payout is stuck. remaining keeps the amount still owed.
               short_d = 1'b1;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (en_1hz) begin
               if (elig_q) begin
                  out_quarter_d = 1'b1;
                  remaining_d   = remaining_q - Q_UNITS;
               end else if (elig_d) begin
                  out_dime_d  = 1'b1;
                  remaining_d = remaining_q - D_UNITS;
               end else begin
                  out_nickel_d = 1'b1;
                  remaining_d  = remaining_q - N_UNITS;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_DISPENSE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         remaining_q   <= '0;
         short_q       <= 1'b0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         out_quarter_q <= 1'b0;
         out_dime_q    <= 1'b0;
         out_nickel_q  <= 1'b0;
         tube_cnt_q    <= INIT_CNT;
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         short_q       <= short_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
         out_quarter_q <= out_quarter_d;
         out_dime_q    <= out_dime_d;
         out_nickel_q  <= out_nickel_d;
         tube_cnt_q    <= tube_cnt_d;
      end
   end

   assign out_quarter = out_quarter_q;
   assign out_dime    = out_dime_q;
   assign out_nickel  = out_nickel_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign short       = short_q;
   assign remaining   = remaining_q;
   assign cnt_q       = tube_cnt_q[0];
   assign cnt_d       = tube_cnt_q[1];
   assign cnt_n       = tube_cnt_q[2];

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//   Directed bench with three instances: default tubes (a), no quarters (b)
//   and no nickels (c). Inputs change on the falling edge, and outputs are
//   sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en_1hz;
   logic [7:0] req_amount;
   logic       coin_quarter, coin_dime, coin_nickel, restock;
   logic       req_valid_a, req_valid_b, req_valid_c;

   logic       req_ready_a, out_quarter_a, out_dime_a, out_nickel_a, busy_a, done_a, short_a;
   logic [7:0] remaining_a;
   logic [3:0] cnt_q_a, cnt_d_a, cnt_n_a;
   logic       req_ready_b, out_quarter_b, out_dime_b, out_nickel_b, busy_b, done_b, short_b;
   logic [7:0] remaining_b;
   logic [3:0] cnt_q_b, cnt_d_b, cnt_n_b;
   logic       req_ready_c, out_quarter_c, out_dime_c, out_nickel_c, busy_c, done_c, short_c;
   logic [7:0] remaining_c;
   logic [3:0] cnt_q_c, cnt_d_c, cnt_n_c;

   int tests = 0;
   int fails = 0;
   int pulses_a = 0;
   int snap;

   always #5 clk = ~clk;

   change_dispenser dut_a (
      .clk(clk), .rst_n(rst_n), .en_1hz(en_1hz), .req_valid(req_valid_a), .req_ready(req_ready_a),
      .req_amount(req_amount), .coin_quarter(coin_quarter), .coin_dime(coin_dime),
      .coin_nickel(coin_nickel), .restock(restock), .out_quarter(out_quarter_a),
      .out_dime(out_dime_a), .out_nickel(out_nickel_a), .busy(busy_a), .done(done_a),
      .short(short_a), .remaining(remaining_a), .cnt_q(cnt_q_a), .cnt_d(cnt_d_a), .cnt_n(cnt_n_a));

   change_dispenser #(.INIT_Q(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .en_1hz(en_1hz), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_amount(req_amount), .coin_quarter(coin_quarter), .coin_dime(coin_dime),
      .coin_nickel(coin_nickel), .restock(restock), .out_quarter(out_quarter_b),
      .out_dime(out_dime_b), .out_nickel(out_nickel_b), .busy(busy_b), .done(done_b),
      .short(short_b), .remaining(remaining_b), .cnt_q(cnt_q_b), .cnt_d(cnt_d_b), .cnt_n(cnt_n_b));

   change_dispenser #(.INIT_N(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .en_1hz(en_1hz), .req_valid(req_valid_c), .req_ready(req_ready_c),
      .req_amount(req_amount), .coin_quarter(coin_quarter), .coin_dime(coin_dime),
      .coin_nickel(coin_nickel), .restock(restock), .out_quarter(out_quarter_c),
      .out_dime(out_dime_c), .out_nickel(out_nickel_c), .busy(busy_c), .done(done_c),
      .short(short_c), .remaining(remaining_c), .cnt_q(cnt_q_c), .cnt_d(cnt_d_c), .cnt_n(cnt_n_c));

   // Count coin ejections on instance a to catch stray pulses.
   always @(negedge clk) begin
      if (out_quarter_a || out_dime_a || out_nickel_a) pulses_a++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic tick();
      en_1hz = 1'b1;
      @(negedge clk);
      en_1hz = 1'b0;
   endtask

   task automatic req(input int which, input logic [7:0] amt);
      req_amount = amt;
      case (which)
         0: req_valid_a = 1'b1;
         1: req_valid_b = 1'b1;
         default: req_valid_c = 1'b1;
      endcase
      @(negedge clk);
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      req_valid_c = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en_1hz = 1'b0; req_amount = '0;
      coin_quarter = 1'b0; coin_dime = 1'b0; coin_nickel = 1'b0; restock = 1'b0;
      req_valid_a = 1'b0; req_valid_b = 1'b0; req_valid_c = 1'b0;
      repeat (3) cyc();

      // Reset state
      check("rst_busy", 32'(busy_a), 0);
      check("rst_done", 32'(done_a), 0);
      check("rst_short", 32'(short_a), 0);
      check("rst_out", 32'({out_quarter_a, out_dime_a, out_nickel_a}), 0);
      check("rst_remaining", 32'(remaining_a), 0);
      check("rst_cnt_q", 32'(cnt_q_a), 8);
      check("rst_cnt_d", 32'(cnt_d_a), 8);
      check("rst_cnt_n", 32'(cnt_n_a), 8);
      check("rst_ready", 32'(req_ready_a), 1);
      rst_n = 1'b1;
      cyc();

      // No quarters: 5 -> D, D, N
      req(1, 8'd5);
      check("nq_busy", 32'(busy_b), 1);
      check("nq_rem0", 32'(remaining_b), 5);
      tick();
      check("nq_p1_dime", 32'({out_quarter_b, out_dime_b, out_nickel_b}), 32'b010);
      check("nq_rem1", 32'(remaining_b), 3);
      cyc();
      check("nq_wait_nopulse", 32'({out_quarter_b, out_dime_b, out_nickel_b}), 0);
      tick();
      check("nq_p2_dime", 32'({out_quarter_b, out_dime_b, out_nickel_b}), 32'b010);
      check("nq_rem2", 32'(remaining_b), 1);
      tick();
      check("nq_p3_nickel", 32'({out_quarter_b, out_dime_b, out_nickel_b}), 32'b001);
      check("nq_rem3", 32'(remaining_b), 0);
      cyc();
      check("nq_done", 32'(done_b), 1);
      check("nq_busy_low", 32'(busy_b), 0);
      check("nq_cnt_d", 32'(cnt_d_b), 6);
      check("nq_cnt_n", 32'(cnt_n_b), 7);
      check("nq_short", 32'(short_b), 0);
      cyc();
      check("nq_done_pulse", 32'(done_b), 0);

      // No nickels: 3 -> D then short with 1 owed
      req(2, 8'd3);
      tick();
      check("nn_dime", 32'({out_quarter_c, out_dime_c, out_nickel_c}), 32'b010);
      check("nn_rem1", 32'(remaining_c), 1);
      cyc();
      check("nn_done", 32'(done_c), 1);
      check("nn_short", 32'(short_c), 1);
      check("nn_rem_hold", 32'(remaining_c), 1);
      check("nn_no_nickel", 32'(out_nickel_c), 0);
      check("nn_cnt_d", 32'(cnt_d_c), 7);
      cyc();
      check("nn_short_sticky", 32'(short_c), 1);

      // Defaults: 13 -> Q, Q, D, N
      req(0, 8'd13);
      check("t1_busy", 32'(busy_a), 1);
      cyc();
      check("t1_waits_tick", 32'({out_quarter_a, out_dime_a, out_nickel_a}), 0);
      check("t1_rem13", 32'(remaining_a), 13);
      tick();
      check("t1_p1_q", 32'({out_quarter_a, out_dime_a, out_nickel_a}), 32'b100);
      check("t1_rem8", 32'(remaining_a), 8);
      tick();
      check("t1_p2_q", 32'({out_quarter_a, out_dime_a, out_nickel_a}), 32'b100);
      check("t1_rem3", 32'(remaining_a), 3);
      tick();
      check("t1_p3_d", 32'({out_quarter_a, out_dime_a, out_nickel_a}), 32'b010);
      check("t1_rem1", 32'(remaining_a), 1);
      tick();
      check("t1_p4_n", 32'({out_quarter_a, out_dime_a, out_nickel_a}), 32'b001);
      check("t1_rem0", 32'(remaining_a), 0);
      check("t1_not_done_yet", 32'(done_a), 0);
      cyc();
      check("t1_done", 32'(done_a), 1);
      check("t1_cnt_q", 32'(cnt_q_a), 6);
      check("t1_cnt_d", 32'(cnt_d_a), 7);
      check("t1_cnt_n", 32'(cnt_n_a), 7);
      check("t1_short", 32'(short_a), 0);
      check("t1_pulses", 32'(pulses_a), 4);

      // Zero request: done two cycles after handshake, no pulses
      snap = pulses_a;
      req(0, 8'd0);
      check("t2_busy", 32'(busy_a), 1);
      check("t2_done_early", 32'(done_a), 0);
      cyc();
      check("t2_done", 32'(done_a), 1);
      check("t2_busy_low", 32'(busy_a), 0);
      check("t2_rem", 32'(remaining_a), 0);
      cyc();
      check("t2_no_pulses", 32'(pulses_a), 32'(snap));

      // Insert and eject of the same tube on one cycle
      req(0, 8'd5);
      coin_quarter = 1'b1;
      tick();
      coin_quarter = 1'b0;
      check("t5_eject_q", 32'(out_quarter_a), 1);
      check("t5_cnt_q_same", 32'(cnt_q_a), 6);
      cyc();
      check("t5_done", 32'(done_a), 1);

      // Saturation from 8
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      coin_quarter = 1'b1;
      repeat (3) cyc();
      check("t5_cnt_q_11", 32'(cnt_q_a), 11);
      repeat (5) cyc();
      coin_quarter = 1'b0;
      check("t5_cnt_q_sat", 32'(cnt_q_a), 15);

      // Restock during DISPENSE waits for IDLE
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      req(0, 8'd13);
      restock = 1'b1;
      tick();
      check("t6_cnt_q_no_refill", 32'(cnt_q_a), 7);
      check("t6_cnt_d_no_refill", 32'(cnt_d_a), 8);
      repeat (3) tick();
      cyc();
      check("t6_done", 32'(done_a), 1);
      check("t6_ready_low", 32'(req_ready_a), 0);
      check("t6_cnt_n_pre", 32'(cnt_n_a), 7);
      cyc();
      check("t6_cnt_q_full", 32'(cnt_q_a), 15);
      check("t6_cnt_d_full", 32'(cnt_d_a), 15);
      check("t6_cnt_n_full", 32'(cnt_n_a), 15);
      check("t6_ready_still_low", 32'(req_ready_a), 0);
      restock = 1'b0;
      cyc();
      check("t6_ready_back", 32'(req_ready_a), 1);

      // Reset mid-dispense
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      req(0, 8'd13);
      tick();
      tick();
      check("t6r_second_q", 32'(out_quarter_a), 1);
      rst_n = 1'b0;
      #1;
      check("t6r_out_cleared", 32'({out_quarter_a, out_dime_a, out_nickel_a}), 0);
      check("t6r_busy", 32'(busy_a), 0);
      check("t6r_cnt_q", 32'(cnt_q_a), 8);
      check("t6r_cnt_d", 32'(cnt_d_a), 8);
      check("t6r_cnt_n", 32'(cnt_n_a), 8);
      check("t6r_rem", 32'(remaining_a), 0);
      snap = pulses_a;
      en_1hz = 1'b1;
      repeat (2) cyc();
      rst_n = 1'b1;
      repeat (3) cyc();
      en_1hz = 1'b0;
      cyc();
      check("t6r_no_more_pulses", 32'(pulses_a), 32'(snap));
      check("t6r_idle", 32'(busy_a), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
